// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit MIPS pipelined datapath.
//   DW / RW / AOPW : datapath, register-index and ALU-opcode widths
//   alu_op_e       : ALU opcode encodings
//   ctrl_t         : control bundle carried down the pipe
//   BUBBLE_CTRL    : control bundle of a no-op bubble (all zeros)
package datapath_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 3;
    localparam int unsigned AOPW = 3;

    typedef enum logic [AOPW-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            alu_src_reg;
        logic [AOPW-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   ex_valid/ex_mem_read/ex_rd : instruction currently in EX
//   id_valid/id_rs/id_rt/id_uses_rs/id_uses_rt : instruction in ID
//   hz : ID reads the register the EX load is about to write (r0 excluded)
module load_use_detect
    import datapath_pkg::*;
(
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rd,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    output logic          hz
);

    always_comb begin
        hz = ex_valid & ex_mem_read & id_valid & (ex_rd != '0) &
             ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubbles.
//   Inputs : decoded operands, immediate, indices and control from ID,
//            flush (wrong-path ID instruction), ex_hold (downstream stall)
//   Outputs: stall (hold PC and IF/ID), registered EX fields, operand-mux
//            select/enable, saturating count of load-use bubbles
module id_ex_stage
    import datapath_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [DW-1:0]   id_imm,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic            id_alu_src_reg,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic [AOPW-1:0] id_alu_op,
    input  logic            flush,
    input  logic            ex_hold,
    output logic            stall,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_rs_data,
    output logic [DW-1:0]   ex_rt_data,
    output logic [DW-1:0]   ex_imm,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_mux_sel,
    output logic            ex_mux_en,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [AOPW-1:0] ex_alu_op,
    output logic [CNTW-1:0] stall_count
);

    logic            valid_q, valid_d;
    logic [DW-1:0]   rs_data_q, rs_data_d;
    logic [DW-1:0]   rt_data_q, rt_data_d;
    logic [DW-1:0]   imm_q, imm_d;
    logic [RW-1:0]   rd_q, rd_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            flush_pend_q, flush_pend_d;
    logic [CNTW-1:0] stall_count_q, stall_count_d;
    logic            hz;

    load_use_detect u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .hz          (hz)
    );

    // A flushed (or pending-flush) ID instruction is discarded anyway, so its
    // hazard must not hold the front end.
    always_comb begin
        stall = rst_n & ((hz & ~flush & ~flush_pend_q) | ex_hold);
    end

    always_comb begin
        valid_d       = valid_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        imm_d         = imm_q;
        rd_d          = rd_q;
        ctrl_d        = ctrl_q;
        flush_pend_d  = flush_pend_q;
        stall_count_d = stall_count_q;

        if (ex_hold) begin
            // Remember a flush that arrives while frozen so the bubble is
            // still inserted once the hold releases.
            if (flush) begin
                flush_pend_d = 1'b1;
            end
        end else if (flush || flush_pend_q || hz) begin
            valid_d      = 1'b0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            rd_d         = '0;
            ctrl_d       = BUBBLE_CTRL;
            flush_pend_d = 1'b0;
            if (!(flush || flush_pend_q) && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end else begin
            valid_d            = id_valid;
            rs_data_d          = id_rs_data;
            rt_data_d          = id_rt_data;
            imm_d              = id_imm;
            rd_d               = id_rd;
            ctrl_d.mem_read    = id_mem_read;
            ctrl_d.mem_write   = id_mem_write;
            ctrl_d.reg_write   = id_reg_write;
            ctrl_d.alu_src_reg = id_alu_src_reg;
            ctrl_d.alu_op      = id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            rd_q          <= '0;
            ctrl_q        <= BUBBLE_CTRL;
            flush_pend_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_q         <= imm_d;
            rd_q          <= rd_d;
            ctrl_q        <= ctrl_d;
            flush_pend_q  <= flush_pend_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_rd        = rd_q;
    assign ex_mux_sel   = ctrl_q.alu_src_reg;
    assign ex_mux_en    = valid_q;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt, id_alu_src_reg;
    logic        id_mem_read, id_mem_write, id_reg_write;
    logic [2:0]  id_alu_op;
    logic        flush, ex_hold;
    logic        stall, ex_valid;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [2:0]  ex_rd;
    logic        ex_mux_sel, ex_mux_en, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_alu_op;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_alu_src_reg(id_alu_src_reg), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_alu_op(id_alu_op), .flush(flush), .ex_hold(ex_hold),
        .stall(stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_mux_sel(ex_mux_sel), .ex_mux_en(ex_mux_en),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_alu_src_reg = 0; id_mem_read = 0; id_mem_write = 0;
        id_reg_write = 0; id_alu_op = 0; flush = 0; ex_hold = 0;
    endtask

    // Put a load writing register rd into EX.
    task automatic load_into_ex(input logic [2:0] rd);
        clear_id();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = rd;
        step();
        clear_id();
    endtask

    task automatic test_reset();
        clear_id();
        rst_n = 0;
        ex_hold = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        step();
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_mux_en !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b/%0b exp=0/0", ex_valid, ex_mux_en);
        end
        checks++;
        if (stall_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", stall_count); end
        clear_id();
        rst_n = 1;
    endtask

    task automatic test_normal_flow();
        clear_id();
        id_valid = 1; id_rs_data = 16'h1234; id_rt_data = 16'h00AA; id_imm = 16'hFFF0;
        id_rd = 2; id_reg_write = 1; id_alu_op = 3'd3; id_alu_src_reg = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL normal_stall got=%0b exp=0", stall); end
        step();
        checks++;
        if (ex_rs_data !== 16'h1234 || ex_imm !== 16'hFFF0 || ex_rt_data !== 16'h00AA) begin
            failures++; $display("FAIL normal_data got=%h/%h/%h exp=1234/fff0/00aa", ex_rs_data, ex_imm, ex_rt_data);
        end
        checks++;
        if (ex_mux_sel !== 1'b0 || ex_mux_en !== 1'b1 || ex_valid !== 1'b1) begin
            failures++; $display("FAIL normal_mux got sel=%0b en=%0b v=%0b exp=0/1/1", ex_mux_sel, ex_mux_en, ex_valid);
        end
        checks++;
        if (ex_rd !== 3'd2 || ex_reg_write !== 1'b1 || ex_alu_op !== 3'd3 || ex_mem_read !== 1'b0) begin
            failures++; $display("FAIL normal_ctrl got rd=%0d rw=%0b op=%0d mr=%0b exp=2/1/3/0", ex_rd, ex_reg_write, ex_alu_op, ex_mem_read);
        end
        clear_id();
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_mux_en !== 1'b0) begin
            failures++; $display("FAIL invalid_id got=%0b/%0b exp=0/0", ex_valid, ex_mux_en);
        end
    endtask

    task automatic test_load_use();
        load_into_ex(3'd3);
        id_valid = 1; id_rs = 3; id_uses_rs = 1; id_rs_data = 16'hAAAA;
        id_rd = 4; id_alu_src_reg = 1; id_reg_write = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
            failures++; $display("FAIL lu_bubble got v=%0b mr=%0b rw=%0b exp=0/0/0", ex_valid, ex_mem_read, ex_reg_write);
        end
        checks++;
        if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", stall_count); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_end got=%0b exp=0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs_data !== 16'hAAAA || ex_rd !== 3'd4 || ex_mux_sel !== 1'b1) begin
            failures++; $display("FAIL lu_reload got v=%0b d=%h rd=%0d sel=%0b exp=1/aaaa/4/1", ex_valid, ex_rs_data, ex_rd, ex_mux_sel);
        end
        checks++;
        if (stall_count !== 16'd1) begin failures++; $display("FAIL lu_count_hold got=%0d exp=1", stall_count); end
        clear_id();
    endtask

    task automatic test_no_hazard();
        load_into_ex(3'd0);
        id_valid = 1; id_rs = 0; id_uses_rs = 1; id_rs_data = 16'h0BB0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0b exp=0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs_data !== 16'h0BB0 || stall_count !== 16'd1) begin
            failures++; $display("FAIL r0_load got v=%0b d=%h cnt=%0d exp=1/0bb0/1", ex_valid, ex_rs_data, stall_count);
        end
        load_into_ex(3'd5);
        id_valid = 1; id_rt = 5; id_uses_rt = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL unused_rt_stall got=%0b exp=0", stall); end
        id_uses_rt = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL used_rt_stall got=%0b exp=1", stall); end
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL flush_suppress got=%0b exp=0", stall); end
        step();
        checks++;
        if (ex_valid !== 1'b0 || stall_count !== 16'd1) begin
            failures++; $display("FAIL flush_bubble got v=%0b cnt=%0d exp=0/1", ex_valid, stall_count);
        end
        clear_id();
    endtask

    task automatic test_flush_hold();
        clear_id();
        id_valid = 1; id_rs_data = 16'h5555; id_rd = 6; id_reg_write = 1;
        step();
        id_rs_data = 16'h7777; id_rd = 1;
        ex_hold = 1; flush = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL hold_stall got=%0b exp=1", stall); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (ex_valid !== 1'b1 || ex_rs_data !== 16'h5555 || ex_rd !== 3'd6) begin
                failures++; $display("FAIL hold_frozen cyc=%0d got v=%0b d=%h rd=%0d exp=1/5555/6", i, ex_valid, ex_rs_data, ex_rd);
            end
        end
        ex_hold = 0; flush = 0;
        id_rs_data = 16'h8888; id_rd = 7;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_rs_data !== 16'h0000 || ex_reg_write !== 1'b0) begin
            failures++; $display("FAIL pend_bubble got v=%0b d=%h rw=%0b exp=0/0000/0", ex_valid, ex_rs_data, ex_reg_write);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs_data !== 16'h8888 || ex_rd !== 3'd7) begin
            failures++; $display("FAIL pend_cleared got v=%0b d=%h rd=%0d exp=1/8888/7", ex_valid, ex_rs_data, ex_rd);
        end
        clear_id();
    endtask

    task automatic test_back_to_back();
        clear_id();
        id_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            id_rs_data = 16'(i * 16'h0101);
            step();
            checks++;
            if (ex_valid !== 1'b1 || ex_rs_data !== 16'(i * 16'h0101)) begin
                failures++; $display("FAIL b2b_%0d got v=%0b d=%h exp=1/%h", i, ex_valid, ex_rs_data, 16'(i * 16'h0101));
            end
        end
        clear_id();
    endtask

    task automatic test_saturation();
        clear_id();
        force dut.stall_count_q = 16'hFFFF;
        step();
        release dut.stall_count_q;
        #1;
        checks++;
        if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_preload got=%h exp=ffff", stall_count); end
        load_into_ex(3'd3);
        id_valid = 1; id_rs = 3; id_uses_rs = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%0b exp=1", stall); end
        step();
        checks++;
        if (stall_count !== 16'hFFFF || ex_valid !== 1'b0) begin
            failures++; $display("FAIL sat_count got=%h v=%0b exp=ffff/0", stall_count, ex_valid);
        end
        clear_id();
    endtask

    task automatic test_reset_mid_stall();
        load_into_ex(3'd2);
        id_valid = 1; id_rt = 2; id_uses_rt = 1; id_rs_data = 16'hCAFE;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL rst_pre_stall got=%0b exp=1", stall); end
        rst_n = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL rst_held_stall got=%0b exp=0", stall); end
        step();
        checks++;
        if (ex_valid !== 0 || ex_mux_en !== 0 || ex_rs_data !== 0 || ex_rd !== 0 ||
            ex_mem_read !== 0 || ex_reg_write !== 0 || stall_count !== 0 || stall !== 0) begin
            failures++; $display("FAIL rst_mid_stall got v=%0b en=%0b d=%h rd=%0d mr=%0b rw=%0b cnt=%h st=%0b exp=all 0",
                                 ex_valid, ex_mux_en, ex_rs_data, ex_rd, ex_mem_read, ex_reg_write, stall_count, stall);
        end
        rst_n = 1;
        clear_id();
        step();
    endtask

    initial begin
        clear_id();
        rst_n = 0;
        test_reset();
        test_normal_flow();
        test_load_use();
        test_no_hazard();
        test_flush_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 16-bit MIPS pipelined datapath, with load-use hazard detection.
- Captures decoded operands, immediate, register indices and control from ID.
- Inserts bubbles on load-use hazards and branch flushes.
- Its registered outputs drive the EX-stage 16-bit 2-to-1 operand mux directly:
  - ex_mux_sel drives select s (1 = register operand on port a, 0 = immediate on port b).
  - ex_mux_en drives enable E.

Parameters:
- DW, 16, datapath width.
- RW, 3, register index width (8 architectural registers, r0 hardwired zero).
- AOPW, 3, ALU opcode width.
- CNTW, 16, stall-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs_data  input  DW  rs operand read from the register file.
- id_rt_data  input  DW  rt operand read from the register file.
- id_imm  input  DW  sign-extended immediate.
- id_rs, id_rt, id_rd  input  RW each  source and destination indices.
- id_uses_rs, id_uses_rt  input  1 each  instruction reads rs / rt.
- id_alu_src_reg  input  1  1 = second ALU operand is rt, 0 = immediate.
- id_mem_read, id_mem_write, id_reg_write  input  1 each  control bits.
- id_alu_op  input  AOPW  ALU operation.
- flush  input  1  ID instruction is wrong-path (branch taken).
- ex_hold  input  1  downstream stall; freeze EX.
- stall  output  1  hold PC and IF/ID this cycle.
- ex_valid  output  1  EX register holds a real instruction.
- ex_rs_data, ex_rt_data, ex_imm  output  DW each  registered operands.
- ex_rd  output  RW  registered destination.
- ex_mux_sel  output  1  to operand mux s.
- ex_mux_en  output  1  to operand mux E; equals ex_valid.
- ex_mem_read, ex_mem_write, ex_reg_write  output  1 each.
- ex_alu_op  output  AOPW.
- stall_count  output  CNTW  saturating count of load-use bubbles.

Behaviour:
- Clocking and reset:
  - All state updates on rising clk.
  - When rst_n=0 at an edge: every output register, flush_pend and stall_count go to 0, so ex_valid=0 and ex_mux_en=0.
  - Reset overrides every other input, including mid-hold and mid-stall.
- Hazard detection (combinational):
  - hz = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- stall output:
  - stall = (hz & ~flush & ~flush_pend) | ex_hold. It is combinational.
  - stall is 0 while rst_n=0.
- Edge priority (after reset):
  1. ex_hold=1: EX register unchanged. If flush=1, set flush_pend=1.
  2. flush=1 or flush_pend=1: load a bubble and clear flush_pend.
  3. hz=1: load a bubble and increment stall_count, saturating at all-ones.
  4. Otherwise: load from ID. ex_valid=id_valid and ex_mux_sel=id_alu_src_reg. All other fields are copied from the ID inputs.
- Bubble:
  - ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mux_sel and ex_alu_op are set to 0.
  - Data fields and ex_rd are don't-care; the implementation zeroes them.
- Timing:
  - Latency ID to EX is exactly 1 cycle when unstalled.
  - A load-use stall lasts exactly 1 cycle, because the next cycle EX holds a bubble and hz deasserts.
- id_valid=0 with no hazard loads a bubble-equivalent (ex_valid=0); it does not count as a stall.
- r0 destination never raises a hazard.
- stall_count never wraps.

Decomposition:
- Shared package (datapath_pkg):
  - DW, RW, AOPW.
  - The ALU opcode constants.
  - Control-bundle struct: mem_read, mem_write, reg_write, alu_src_reg, alu_op.
  - BUBBLE_CTRL constant, all zeros.
- One sub-module, load_use_detect: purely combinational hz generation, reusable by the forwarding unit.
- Pipeline register, flush_pend and counter stay in id_ex_stage.

Test Plan:
- Normal flow: id_valid=1, id_rs_data=16'h1234, id_imm=16'hFFF0, id_alu_src_reg=0 -> next cycle ex_rs_data=16'h1234, ex_imm=16'hFFF0, ex_mux_sel=0, ex_mux_en=1, stall=0.
- Load-use: EX holds a load with ex_rd=3; ID has id_rs=3, id_uses_rs=1 -> stall=1 for one cycle, then EX is a bubble (ex_valid=0), stall_count=1. The following cycle the ID instruction loads.
- r0 / unused operand:
  - ex_rd=0 with a load, id_rs=0 -> stall=0.
  - ex_rd=5, id_rt=5, id_uses_rt=0 -> stall=0.
- Flush during hold: ex_hold=1 and flush=1 for 2 cycles, then release -> EX unchanged during hold, then a bubble is loaded and flush_pend=0.
- Saturation: force stall_count to 16'hFFFF and trigger a load-use -> stall_count stays 16'hFFFF.
- Reset mid-stall: rst_n=0 while hz=1 -> next edge all outputs 0, stall=0 while reset is held; stall_count=0.
